usart_receiver: RTL and testbench

Receive half of the USART path: recovers 8N1 serial frames (1 start, 8 data, no parity, 1 stop) from the `rx_pin` line and presents each byte in a holding register with a valid/read handshake. It sits between the board RX pin and the processor-side register interface. It uses the same 16-bit `prescaler` bit-period value as the transmit side, so one register setting drives both directions.

---
 rtl/usart_receiver.sv | 149 ++++++++++++++
 tb/tb_usart_receiver.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/usart_receiver.sv
// 8N1 serial receiver: synchronizes rx_pin, samples each bit mid-period using a latched
// prescaler, and holds the received byte behind a valid/read handshake with sticky error flags.
module usart_receiver #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [0:15] prescaler,
    input  logic        rx_pin,
    input  logic        rd,
    output logic [0:7]  rx_data,
    output logic        rx_valid,
    output logic        frame_error,
    output logic        overrun,
    output logic        rx_busy
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitIdle
    } state_e;

    state_e                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic                   rxs_d;
    logic [15:0]            period_q;
    logic [15:0]            half_q;
    logic [15:0]            cnt_q;
    logic [2:0]             bit_idx_q;
    logic [0:7]             shift_q;
    logic                   load_q;
    logic                   ferr_q;
    logic [15:0]            p_eff;
    logic [15:0]            target;
    logic                   tick;

    assign rxs    = sync_q[SYNC_STAGES-1];
    assign p_eff  = (prescaler < 16'd2) ? 16'd2 : prescaler;
    assign target = (state_q == StStart) ? half_q : period_q;
    assign tick   = (cnt_q == target - 16'd1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            sync_q      <= '1;
            rxs_d       <= 1'b1;
            period_q    <= 16'd0;
            half_q      <= 16'd0;
            cnt_q       <= 16'd0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            load_q      <= 1'b0;
            ferr_q      <= 1'b0;
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
            rx_busy     <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_pin};
            rxs_d  <= rxs;
            load_q <= 1'b0;
            ferr_q <= 1'b0;
            cnt_q  <= cnt_q + 16'd1;

            // Stop-bit outcome is applied one cycle after the sample; a load beats a read.
            if (load_q) begin
                rx_data     <= shift_q;
                rx_valid    <= 1'b1;
                overrun     <= rd ? 1'b0 : (overrun | rx_valid);
                frame_error <= rd ? 1'b0 : frame_error;
            end else if (ferr_q) begin
                frame_error <= 1'b1;
                if (rd) begin
                    rx_valid <= 1'b0;
                    overrun  <= 1'b0;
                end
            end else if (rd) begin
                rx_valid    <= 1'b0;
                overrun     <= 1'b0;
                frame_error <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    cnt_q <= 16'd0;
                    if (rxs_d && !rxs) begin
                        state_q  <= StStart;
                        period_q <= p_eff;
                        half_q   <= p_eff >> 1;
                        rx_busy  <= 1'b1;
                    end
                end
                StStart: begin
                    if (tick) begin
                        cnt_q <= 16'd0;
                        if (!rxs) begin
                            state_q   <= StData;
                            bit_idx_q <= 3'd0;
                        end else begin
                            state_q <= StIdle;
                            rx_busy <= 1'b0;
                        end
                    end
                end
                StData: begin
                    if (tick) begin
                        cnt_q     <= 16'd0;
                        shift_q   <= {rxs, shift_q[0:6]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= StStop;
                        end
                    end
                end
                StStop: begin
                    if (tick) begin
                        cnt_q <= 16'd0;
                        if (rxs) begin
                            // Back to idle at mid-stop so a following start edge is caught.
                            load_q  <= 1'b1;
                            state_q <= StIdle;
                            rx_busy <= 1'b0;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= StWaitIdle;
                        end
                    end
                end
                StWaitIdle: begin
                    if (rxs) begin
                        cnt_q   <= 16'd0;
                        state_q <= StIdle;
                        rx_busy <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usart_receiver.sv
// Directed bench for usart_receiver: hand-built frames driven cell by cell, immediate-assertion
// checks on data, flags, timing and handshake corner cases.
module tb_usart_receiver;

    logic        clock;
    logic        reset;
    logic [0:15] prescaler;
    logic        rx_pin;
    logic        rd;
    logic [0:7]  rx_data;
    logic        rx_valid;
    logic        frame_error;
    logic        overrun;
    logic        rx_busy;

    int total;
    int passed;
    int fails;
    int valid_edge;
    int busy_low;
    int busy_seen;

    usart_receiver #(.SYNC_STAGES(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .prescaler   (prescaler),
        .rx_pin      (rx_pin),
        .rd          (rd),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_error (frame_error),
        .overrun     (overrun),
        .rx_busy     (rx_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives ncells line cells of p cycles each, LSB of pat first; starts and ends just after
    // a negedge. Edge e counts posedges since the call; rd is high for the cycle ending at rd_at.
    task automatic drive_bits(input logic [15:0] pat, input int ncells, input int p,
                              input int rd_at);
        logic prev;
        valid_edge = 0;
        busy_low   = 0;
        busy_seen  = 0;
        prev       = rx_valid;
        for (int c = 0; c < ncells * p; c++) begin
            rx_pin = pat[c / p];
            rd     = ((c + 1) == rd_at);
            @(posedge clock);
            #1;
            if (rx_valid && !prev && valid_edge == 0) valid_edge = c + 1;
            prev = rx_valid;
            if (rx_busy) busy_seen = 1;
            else if ((c + 1) >= 3 && (c + 1) <= 2 + p / 2 + 9 * p) busy_low++;
            @(negedge clock);
        end
        rx_pin = 1'b1;
        rd     = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    task automatic pulse_rd();
        rd = 1'b1;
        @(posedge clock);
        #1;
        @(negedge clock);
        rd = 1'b0;
    endtask

    initial begin
        total     = 0;
        passed    = 0;
        fails     = 0;
        reset     = 1'b0;
        rx_pin    = 1'b1;
        rd        = 1'b0;
        prescaler = 16'd16;
        repeat (3) @(negedge clock);
        check("reset_data", 32'(rx_data), 32'h00);
        check("reset_valid", 32'(rx_valid), 32'h0);
        check("reset_ferr", 32'(frame_error), 32'h0);
        check("reset_ovr", 32'(overrun), 32'h0);
        check("reset_busy", 32'(rx_busy), 32'h0);
        reset = 1'b1;
        idle(5);

        // Good frame 0xA5 at P=16: valid at H+9P+S+2 = 8+144+2+2 = 156.
        drive_bits({2'b11, 8'hA5, 1'b0}, 11, 16, 0);
        check("a5_valid_edge", 32'(valid_edge), 32'd156);
        check("a5_data", 32'(rx_data), 32'hA5);
        check("a5_busy_gaps", 32'(busy_low), 32'd0);
        pulse_rd();
        check("a5_rd_clears", 32'(rx_valid), 32'h0);

        // Four-cycle glitch: enters START, returns to IDLE, no flags.
        drive_bits(16'hFFFE, 8, 4, 0);
        check("glitch_busy_seen", 32'(busy_seen), 32'd1);
        check("glitch_busy_end", 32'(rx_busy), 32'h0);
        check("glitch_valid", 32'(rx_valid), 32'h0);
        check("glitch_ferr", 32'(frame_error), 32'h0);
        check("glitch_ovr", 32'(overrun), 32'h0);

        // 0x3C with stop held low for three bit times; line still low when this returns.
        drive_bits({3'b000, 8'h3C, 1'b0}, 12, 16, 0);
        check("fe_flag", 32'(frame_error), 32'h1);
        check("fe_wait_busy", 32'(rx_busy), 32'h1);
        check("fe_data_kept", 32'(rx_data), 32'hA5);
        check("fe_valid", 32'(rx_valid), 32'h0);
        drive_bits(16'h0001, 1, 16, 0);
        check("fe_exit_busy", 32'(rx_busy), 32'h0);
        drive_bits({2'b11, 8'h81, 1'b0}, 11, 16, 0);
        check("fe_next_edge", 32'(valid_edge), 32'd156);
        check("fe_next_data", 32'(rx_data), 32'h81);
        check("fe_sticky", 32'(frame_error), 32'h1);
        pulse_rd();
        check("fe_rd_clears", 32'(frame_error), 32'h0);

        // Two frames without a read: overrun.
        drive_bits({2'b11, 8'h11, 1'b0}, 11, 16, 0);
        drive_bits({2'b11, 8'h22, 1'b0}, 11, 16, 0);
        check("ovr_data", 32'(rx_data), 32'h22);
        check("ovr_valid", 32'(rx_valid), 32'h1);
        check("ovr_flag", 32'(overrun), 32'h1);
        pulse_rd();
        check("ovr_rd_valid", 32'(rx_valid), 32'h0);
        check("ovr_rd_flag", 32'(overrun), 32'h0);
        check("ovr_rd_ferr", 32'(frame_error), 32'h0);

        // Read in the very cycle the second byte loads: load wins, no overrun.
        drive_bits({2'b11, 8'h33, 1'b0}, 11, 16, 0);
        drive_bits({2'b11, 8'h44, 1'b0}, 11, 16, 156);
        check("rdload_valid", 32'(rx_valid), 32'h1);
        check("rdload_ovr", 32'(overrun), 32'h0);
        check("rdload_data", 32'(rx_data), 32'h44);

        // Reset during data bit 4 of 0xFF while 0x44 is still unread.
        drive_bits(16'h001E, 5, 16, 0);
        idle(8);
        check("rst_busy_before", 32'(rx_busy), 32'h1);
        reset = 1'b0;
        #1;
        check("rst_data", 32'(rx_data), 32'h00);
        check("rst_valid", 32'(rx_valid), 32'h0);
        check("rst_ferr", 32'(frame_error), 32'h0);
        check("rst_ovr", 32'(overrun), 32'h0);
        check("rst_busy", 32'(rx_busy), 32'h0);
        @(negedge clock);
        idle(2);
        reset = 1'b1;
        idle(80);
        check("rst_no_resync", 32'(rx_valid), 32'h0);

        // New prescaler between frames: P=8, valid at 4+72+2+2 = 80.
        prescaler = 16'd8;
        drive_bits({2'b11, 8'h5A, 1'b0}, 11, 8, 0);
        check("p8_valid_edge", 32'(valid_edge), 32'd80);
        check("p8_data", 32'(rx_data), 32'h5A);
        pulse_rd();

        // Prescaler 1 behaves as 2: valid at 1+18+2+2 = 23.
        prescaler = 16'd1;
        drive_bits({3'b111, 8'h96, 1'b0}, 13, 2, 0);
        check("p1_valid_edge", 32'(valid_edge), 32'd23);
        check("p1_data", 32'(rx_data), 32'h96);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
